// File: rtl/bnn_pkg.sv
// Shared BNN pipeline types and default sizing.
// The argmax FSM state and the class/popcount widths shared with the output neuron.
package bnn_pkg;

  localparam int BNN_NUM_CLASSES = 10;
  localparam int BNN_THRESH_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/output_argmax.sv
// Sequential argmax over one captured popcount vector; lowest index wins ties.
// Latency: result valid NUM_CLASSES-1 cycles after accept, held until out_ready.
// Backpressure: none on input; vectors offered while busy are dropped and flagged in sticky overrun.
module output_argmax
  import bnn_pkg::*;
#(
  parameter int  NUM_CLASSES = BNN_NUM_CLASSES,
  parameter int  THRESH_W    = BNN_THRESH_W,
  localparam int CLS_W       = $clog2(NUM_CLASSES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_CLASSES*THRESH_W-1:0] in_popcount,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CLS_W-1:0]                out_class,
  output logic [THRESH_W-1:0]             out_max,
  output logic                            overrun
);

  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

  argmax_state_t       state_q, state_d;
  logic [CLS_W-1:0]    idx_q, idx_d;
  logic [CLS_W-1:0]    best_idx_q, best_idx_d;
  logic [THRESH_W-1:0] best_val_q, best_val_d;
  logic [THRESH_W-1:0] vec_q [NUM_CLASSES];
  logic [THRESH_W-1:0] vec_d [NUM_CLASSES];
  logic                overrun_q, overrun_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_class = best_idx_q;
  assign out_max   = best_val_q;
  assign overrun   = overrun_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    vec_d      = vec_q;
    // Any offer outside IDLE is lost, including one coinciding with the DONE handshake.
    overrun_d  = overrun_q | (in_valid & ~in_ready);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            vec_d[i] = in_popcount[i*THRESH_W +: THRESH_W];
          end
          best_val_d = in_popcount[THRESH_W-1:0];
          best_idx_d = '0;
          idx_d      = CLS_W'(1);
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (vec_q[idx_q] > best_val_q) begin
          best_val_d = vec_q[idx_q];
          best_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      overrun_q  <= overrun_d;
      vec_q      <= vec_d;
    end
  end

endmodule
